// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer in front of a combinational 8-bit ALU: fetches operands
// from a small register file, drives the ALU, then writes back result and flags.
module alu_exec_ctrl #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [7:0]        instr_opcode,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic [REG_AW-1:0] instr_rs1,
    input  logic [REG_AW-1:0] instr_rs2,
    input  logic [DATA_W-1:0] instr_imm,
    output logic [7:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_negative,
    output logic [2:0]        flags,
    output logic              done,
    output logic              illegal,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [2:0]        dbg_state
);

    // Handshake: an instruction transfers on a rising edge where instr_valid and
    // instr_ready are both high; instr_ready is high only while the sequencer is idle.

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD_A = 3'd1;
    localparam logic [2:0] S_RD_B = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;

    localparam int NREGS = 1 << REG_AW;

    localparam logic [7:0] OP_XOR   = 8'h04;
    localparam logic [7:0] OP_LOADI = 8'h10;

    logic [2:0]        state;
    logic [DATA_W-1:0] regs [NREGS];

    logic [7:0]        op_q;
    logic [REG_AW-1:0] rd_q;
    logic [REG_AW-1:0] rs1_q;
    logic [REG_AW-1:0] rs2_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] res_q;
    logic [2:0]        flg_q;

    logic              accept;
    logic              in_is_alu;
    logic              op_is_alu;
    logic              op_is_loadi;
    logic [REG_AW-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    // Opcodes 0x00..0x04 go through the ALU; LOADI bypasses it.
    assign in_is_alu   = (instr_opcode <= OP_XOR);
    assign op_is_alu   = (op_q <= OP_XOR);
    assign op_is_loadi = (op_q == OP_LOADI);

    assign accept      = instr_valid && (state == S_IDLE);
    assign instr_ready = (state == S_IDLE);
    assign done        = (state == S_WB);
    assign illegal     = (state == S_WB) && !op_is_alu && !op_is_loadi;
    assign dbg_state   = state;

    // Single operand read port, time-shared between the two read states.
    assign rd_addr  = (state == S_RD_A) ? rs1_q : rs2_q;
    assign rd_data  = regs[rd_addr];
    assign dbg_data = regs[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            res_q      <= '0;
            flg_q      <= '0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            flags      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q  <= instr_opcode;
                        rd_q  <= instr_rd;
                        rs1_q <= instr_rs1;
                        rs2_q <= instr_rs2;
                        imm_q <= instr_imm;
                        state <= in_is_alu ? S_RD_A : S_WB;
                    end
                end
                S_RD_A: begin
                    alu_a <= rd_data;
                    state <= S_RD_B;
                end
                S_RD_B: begin
                    alu_b      <= rd_data;
                    alu_opcode <= op_q;
                    state      <= S_EXEC;
                end
                S_EXEC: begin
                    res_q <= alu_result;
                    flg_q <= {alu_zero, alu_carry, alu_negative};
                    state <= S_WB;
                end
                S_WB: begin
                    if (op_is_alu) begin
                        flags <= flg_q;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Register file is written only at the end of the write-back cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (state == S_WB) begin
            if (op_is_alu) begin
                regs[rd_q] <= res_q;
            end else if (op_is_loadi) begin
                regs[rd_q] <= imm_q;
            end
        end
    end

endmodule
